// File: rtl/ps2_mouse_tracker_if.sv
// Register bus between the system side and the PS/2 mouse tracker.
// Master drives address/strobes/write data; the tracker returns registered read data.
interface ps2_mouse_tracker_if;
  logic [7:0] Addr;
  logic       RD;
  logic       WR;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  // RD/WR are single-cycle strobes sampled on Clk; DataOut is valid one cycle after RD and holds otherwise.
  modport master (output Addr, RD, WR, DataIn, input DataOut);
  modport slave  (input Addr, RD, WR, DataIn, output DataOut);
endinterface

// File: rtl/ps2_mouse_tracker.sv
// Receive-only PS/2 mouse front end with a clamped absolute-position tracker on an 8-bit register bus.
// Optional feature macro: PS2_MOUSE_WHEEL_EN (4-byte IntelliMouse packets with an 8-bit WHEEL accumulator).
module ps2_mouse_tracker #(
  parameter int POS_W       = 16,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  PS2Clk,
  input  logic                  PS2Data,
  ps2_mouse_tracker_if.slave    bus,
  output logic                  Irq
);
  localparam int PW = POS_W + 2;
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic signed [PW-1:0] XMAX_S = PW'(X_MAX);
  localparam logic signed [PW-1:0] YMAX_S = PW'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} frame_state_e;

  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic fall;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_s1_q <= PS2Clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2Data;
      dat_s2_q <= dat_s1_q;
      // The filtered level flips only after FILT_LEN consecutive disagreeing samples.
      if (clk_s2_q == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
        filt_q     <= clk_s2_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_q && !clk_s2_q && (filt_cnt_q == FW'(FILT_LEN - 1));

  frame_state_e state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q;
  logic          byte_ok, frame_err, tmo_hit;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= (state_q == S_IDLE || fall || tmo_hit) ? '0 : tmo_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    tmo_hit   = (state_q != S_IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYC - 1));
    if (tmo_hit) begin
      state_d = S_IDLE;
    end else if (fall) begin
      case (state_q)
        S_IDLE: if (!dat_s2_q) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
        S_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (dat_s2_q && (^{shift_q, par_q})) byte_ok = 1'b1;
          else                                 frame_err = 1'b1;
        end
      endcase
    end
  end

  // Packet assembly keeps only the header fields that the commit actually uses.
  logic [1:0] idx_q;
  logic [2:0] pbtn_q;
  logic       povf_q, xs_q, ys_q;
  logic [7:0] dx_q, dy_q;
  logic       commit_q;
`ifdef PS2_MOUSE_WHEEL_EN
  logic [3:0] dz_q;
  logic [7:0] wheel_q;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_q    <= '0;
      pbtn_q   <= '0;
      povf_q   <= 1'b0;
      xs_q     <= 1'b0;
      ys_q     <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      commit_q <= 1'b0;
`ifdef PS2_MOUSE_WHEEL_EN
      dz_q     <= '0;
`endif
    end else begin
      commit_q <= 1'b0;
      if (frame_err || tmo_hit) begin
        idx_q <= '0;
      end else if (byte_ok) begin
        case (idx_q)
          2'd0: if (shift_q[3]) begin
            pbtn_q <= shift_q[2:0];
            xs_q   <= shift_q[4];
            ys_q   <= shift_q[5];
            povf_q <= |shift_q[7:6];
            idx_q  <= 2'd1;
          end
          2'd1: begin
            dx_q  <= shift_q;
            idx_q <= 2'd2;
          end
`ifdef PS2_MOUSE_WHEEL_EN
          2'd2: begin
            dy_q  <= shift_q;
            idx_q <= 2'd3;
          end
          default: begin
            dz_q     <= shift_q[3:0];
            idx_q    <= 2'd0;
            commit_q <= 1'b1;
          end
`else
          default: begin
            dy_q     <= shift_q;
            idx_q    <= 2'd0;
            commit_q <= 1'b1;
          end
`endif
        endcase
      end
    end
  end

  logic [POS_W-1:0] x_q, y_q, x_new, y_new;
  logic signed [PW-1:0] dx_s, dy_s, x_sum, y_sum;

  // PS/2 +dy means up, while screen Y grows downward.
  always_comb begin
    dx_s  = {{(PW-9){xs_q}}, xs_q, dx_q};
    dy_s  = {{(PW-9){ys_q}}, ys_q, dy_q};
    x_sum = $signed({2'b00, x_q}) + dx_s;
    y_sum = $signed({2'b00, y_q}) - dy_s;
    if (x_sum[PW-1])         x_new = '0;
    else if (x_sum > XMAX_S) x_new = POS_W'(X_MAX);
    else                     x_new = x_sum[POS_W-1:0];
    if (y_sum[PW-1])         y_new = '0;
    else if (y_sum > YMAX_S) y_new = POS_W'(Y_MAX);
    else                     y_new = y_sum[POS_W-1:0];
  end

  logic       new_q, err_q, ovf_q, irq_en_q, home_q;
  logic [2:0] btn_q;
  logic [7:0] pkt_cnt_q, dout_q, shadow_xhi_q, rd_data;
  logic [15:0] shadow_y_q, x16, y16;
  logic       wr_status, wr_ctrl;

  assign x16       = 16'(x_q);
  assign y16       = 16'(y_q);
  assign wr_status = bus.WR && (bus.Addr == 8'h00);
  assign wr_ctrl   = bus.WR && (bus.Addr == 8'h08);

  always_comb begin
    rd_data = 8'h00;
    case (bus.Addr)
      8'h00: rd_data = {5'b0, ovf_q, err_q, new_q};
      8'h01: rd_data = {5'b0, btn_q};
      8'h02: rd_data = x16[7:0];
      8'h03: rd_data = shadow_xhi_q;
      8'h04: rd_data = shadow_y_q[7:0];
      8'h05: rd_data = shadow_y_q[15:8];
      8'h06: rd_data = pkt_cnt_q;
`ifdef PS2_MOUSE_WHEEL_EN
      8'h07: rd_data = wheel_q;
`endif
      8'h08: rd_data = {6'b0, irq_en_q, 1'b0};
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      new_q        <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      home_q       <= 1'b0;
      btn_q        <= '0;
      pkt_cnt_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      dout_q       <= '0;
      shadow_xhi_q <= '0;
      shadow_y_q   <= '0;
`ifdef PS2_MOUSE_WHEEL_EN
      wheel_q      <= '0;
`endif
    end else begin
      home_q <= wr_ctrl && bus.DataIn[0];
      if (wr_ctrl) irq_en_q <= bus.DataIn[1];
      // Hardware set beats a same-cycle write-1-to-clear.
      new_q <= commit_q | (new_q & ~(wr_status & bus.DataIn[0]));
      err_q <= frame_err | (err_q & ~(wr_status & bus.DataIn[1]));
      ovf_q <= (commit_q & povf_q) | (ovf_q & ~(wr_status & bus.DataIn[2]));
      if (commit_q) begin
        btn_q     <= pbtn_q;
        pkt_cnt_q <= pkt_cnt_q + 8'd1;
        if (!povf_q) begin
          x_q <= x_new;
          y_q <= y_new;
        end
`ifdef PS2_MOUSE_WHEEL_EN
        wheel_q <= wheel_q + {{4{dz_q[3]}}, dz_q};
`endif
      end else if (home_q) begin
        x_q <= '0;
        y_q <= '0;
      end
      if (bus.RD) begin
        dout_q <= rd_data;
        if (bus.Addr == 8'h02) begin
          shadow_xhi_q <= x16[15:8];
          shadow_y_q   <= y16;
        end
      end
    end
  end

  assign bus.DataOut = dout_q;
  assign Irq         = new_q & irq_en_q;
endmodule
